spm_mem_sched: RTL and testbench

- Shares the single DCP memory request/response port between the three SpMV fetch streams: VAL (values), COL (column indices), ROW (row lengths).
- Sits between the per-stream fetch engines and the NoC memory interface.
- Round-robin arbitrates requests, allocates transaction IDs, enforces a per-stream outstanding-credit limit, and routes responses back to the owning stream by transid.
- Sequences run/drain so a matrix fetch can be flushed cleanly.

---
 rtl/spm_mem_sched.sv | 178 +++++++++++++++++
 tb/tb_spm_mem_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_mem_sched.sv
// Memory request scheduler for the three SpMV fetch streams (VAL/COL/ROW).
// Optional statistics counters: define SPM_SCHED_STATS_EN.
module spm_mem_sched #(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_start,
    input  logic                  sched_flush,
    output logic                  sched_busy,
    output logic                  sched_done,
    input  logic [2:0]            ch_req_val,
    input  logic [3*ADDR_W-1:0]   ch_req_addr,
    output logic [2:0]            ch_req_rdy,
    output logic                  mem_req_val,
    input  logic                  mem_req_rdy,
    output logic [5:0]            mem_req_transid,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_resp_val,
    input  logic [5:0]            mem_resp_transid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic [2:0]            ch_resp_val,
    output logic [3:0]            ch_resp_seq,
`ifdef SPM_SCHED_STATS_EN
    output logic [31:0]           stat_req_cnt,
    output logic [31:0]           stat_stall_cnt,
`endif
    output logic [DATA_W-1:0]     ch_resp_data
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [3:0] MAXC = 4'(MAX_OUT);

    state_t              state;
    state_t              state_nx;
    logic [3:0]          credit [3];
    logic [3:0]          seq [3];
    logic [1:0]          ptr;
    logic                rv;
    logic [ADDR_W-1:0]   raddr;
    logic [5:0]          rtid;

    logic                can_load;
    logic                gany;
    logic [1:0]          gidx;
    logic [2:0]          s;
    logic [2:0]          elig;
    logic [2:0]          grant;
    logic [2:0]          hit;
    logic [ADDR_W-1:0]   gaddr;
    logic [3:0]          gseq;
    logic                all_zero;

    assign mem_req_val     = rv;
    assign mem_req_addr    = raddr;
    assign mem_req_transid = rtid;
    assign sched_busy      = (state != IDLE);
    assign can_load        = !rv || mem_req_rdy;
    assign all_zero        = (credit[0] == 4'd0) && (credit[1] == 4'd0)
                           && (credit[2] == 4'd0);

    always_comb begin
        elig = 3'b000;
        for (int i = 0; i < 3; i++) begin
            elig[i] = (state == RUN) && ch_req_val[i] && (credit[i] < MAXC);
        end
    end

    // Search order starts at the RR pointer and wraps VAL->COL->ROW.
    always_comb begin
        gany = 1'b0;
        gidx = 2'd0;
        s    = 3'd0;
        for (int k = 0; k < 3; k++) begin
            s = {1'b0, ptr} + 3'(k);
            if (s >= 3'd3) s = s - 3'd3;
            if (!gany && elig[s[1:0]]) begin
                gany = 1'b1;
                gidx = s[1:0];
            end
        end
    end

    always_comb begin
        grant = 3'b000;
        gaddr = '0;
        gseq  = 4'd0;
        if (gany && can_load) grant = 3'b001 << gidx;
        for (int i = 0; i < 3; i++) begin
            if (gidx == 2'(i)) begin
                gaddr = ch_req_addr[i*ADDR_W +: ADDR_W];
                gseq  = seq[i];
            end
        end
    end

    assign ch_req_rdy = grant;

    // Responses to streams with no credit (e.g. stale after reset) are dropped.
    always_comb begin
        hit = 3'b000;
        for (int i = 0; i < 3; i++) begin
            hit[i] = mem_resp_val && (mem_resp_transid[5:4] == 2'(i))
                   && (credit[i] != 4'd0);
        end
    end

    assign ch_resp_val  = hit;
    assign ch_resp_seq  = (|hit) ? mem_resp_transid[3:0] : 4'd0;
    assign ch_resp_data = (|hit) ? mem_resp_data : '0;

    always_comb begin
        state_nx   = state;
        sched_done = 1'b0;
        unique case (state)
            IDLE:  if (sched_start) state_nx = RUN;
            RUN:   if (sched_flush) state_nx = DRAIN;
            DRAIN: begin
                if (all_zero) begin
                    state_nx   = IDLE;
                    sched_done = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            rv    <= 1'b0;
            raddr <= '0;
            rtid  <= 6'd0;
            for (int i = 0; i < 3; i++) begin
                credit[i] <= 4'd0;
                seq[i]    <= 4'd0;
            end
        end else begin
            state <= state_nx;
            if (|grant) begin
                rv    <= 1'b1;
                raddr <= gaddr;
                rtid  <= {gidx, gseq};
                ptr   <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            end else if (mem_req_rdy) begin
                rv <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (grant[i]) seq[i] <= seq[i] + 4'd1;
                if (grant[i] && !hit[i]) credit[i] <= credit[i] + 4'd1;
                else if (!grant[i] && hit[i]) credit[i] <= credit[i] - 4'd1;
            end
        end
    end

`ifdef SPM_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && sched_start)) begin
            stat_req_cnt   <= 32'd0;
            stat_stall_cnt <= 32'd0;
        end else begin
            if (rv && mem_req_rdy && !(&stat_req_cnt))
                stat_req_cnt <= stat_req_cnt + 32'd1;
            if (rv && !mem_req_rdy && !(&stat_stall_cnt))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spm_mem_sched.sv
// Directed self-checking bench for spm_mem_sched.
// Stats checks are active when SPM_SCHED_STATS_EN is defined.
module tb_spm_mem_sched;

    localparam int AW = 40;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            sched_start;
    logic            sched_flush;
    logic            sched_busy;
    logic            sched_done;
    logic [2:0]      ch_req_val;
    logic [3*AW-1:0] ch_req_addr;
    logic [2:0]      ch_req_rdy;
    logic            mem_req_val;
    logic            mem_req_rdy;
    logic [5:0]      mem_req_transid;
    logic [AW-1:0]   mem_req_addr;
    logic            mem_resp_val;
    logic [5:0]      mem_resp_transid;
    logic [DW-1:0]   mem_resp_data;
    logic [2:0]      ch_resp_val;
    logic [3:0]      ch_resp_seq;
    logic [DW-1:0]   ch_resp_data;
`ifdef SPM_SCHED_STATS_EN
    logic [31:0]     stat_req_cnt;
    logic [31:0]     stat_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spm_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .sched_start      (sched_start),
        .sched_flush      (sched_flush),
        .sched_busy       (sched_busy),
        .sched_done       (sched_done),
        .ch_req_val       (ch_req_val),
        .ch_req_addr      (ch_req_addr),
        .ch_req_rdy       (ch_req_rdy),
        .mem_req_val      (mem_req_val),
        .mem_req_rdy      (mem_req_rdy),
        .mem_req_transid  (mem_req_transid),
        .mem_req_addr     (mem_req_addr),
        .mem_resp_val     (mem_resp_val),
        .mem_resp_transid (mem_resp_transid),
        .mem_resp_data    (mem_resp_data),
        .ch_resp_val      (ch_resp_val),
        .ch_resp_seq      (ch_resp_seq),
`ifdef SPM_SCHED_STATS_EN
        .stat_req_cnt     (stat_req_cnt),
        .stat_stall_cnt   (stat_stall_cnt),
`endif
        .ch_resp_data     (ch_resp_data)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        sched_start      = 1'b0;
        sched_flush      = 1'b0;
        ch_req_val       = 3'b000;
        ch_req_addr      = '0;
        mem_req_rdy      = 1'b0;
        mem_resp_val     = 1'b0;
        mem_resp_transid = 6'd0;
        mem_resp_data    = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        sched_start = 1'b1;
        step();
        sched_start = 1'b0;
    endtask

    int n;
    int g;
    int h;
    logic [5:0] last;
    logic [5:0] exp_tid;
    logic [1:0] st;

    initial begin
        // reset and idle
        do_reset();
        #1;
        chk("rst_busy", 64'(sched_busy), 64'd0);
        chk("rst_mval", 64'(mem_req_val), 64'd0);
        chk("rst_tid", 64'(mem_req_transid), 64'd0);
        mem_resp_val = 1'b1;
        #1;
        chk("rst_resp_drop", 64'(ch_resp_val), 64'd0);
        mem_resp_val = 1'b0;
        ch_req_val   = 3'b111;
        mem_req_rdy  = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            #1;
            if (ch_req_rdy != 3'b000 || mem_req_val) n++;
        end
        chk("idle_no_grant", 64'(n), 64'd0);

        // round robin
        do_reset();
        start_run();
        ch_req_val  = 3'b111;
        ch_req_addr = {40'h3000, 40'h2000, 40'h1000};
        mem_req_rdy = 1'b1;
        #1;
        chk("rr_first_rdy", 64'(ch_req_rdy), 64'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 5) ch_req_val = 3'b000;
            #1;
            st      = 2'(k % 3);
            exp_tid = {st, 4'(k / 3)};
            chk("rr_mval", 64'(mem_req_val), 64'd1);
            chk("rr_tid", 64'(mem_req_transid), 64'(exp_tid));
            chk("rr_addr", 64'(mem_req_addr), 64'h1000 * 64'(k % 3 + 1));
        end
        step();
        #1;
        chk("rr_empty", 64'(mem_req_val), 64'd0);

        // credit limit
        do_reset();
        start_run();
        ch_req_val  = 3'b001;
        ch_req_addr = {40'h0, 40'h0, 40'h1000};
        mem_req_rdy = 1'b1;
        n = 0;
        last = 6'h3f;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ch_req_rdy[0]) n++;
            if (mem_req_val) last = mem_req_transid;
            step();
        end
        #1;
        chk("cred_grants", 64'(n), 64'd4);
        chk("cred_last_tid", 64'(last), 64'h03);
        chk("cred_blocked", 64'(ch_req_rdy), 64'd0);
        mem_resp_val     = 1'b1;
        mem_resp_transid = 6'h02;
        mem_resp_data    = 64'hdead_beef_0123_4567;
        #1;
        chk("resp_val", 64'(ch_resp_val), 64'b001);
        chk("resp_seq", 64'(ch_resp_seq), 64'd2);
        chk("resp_data", ch_resp_data, 64'hdead_beef_0123_4567);
        step();
        mem_resp_val = 1'b0;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ch_req_rdy[0]) n++;
            if (mem_req_val) last = mem_req_transid;
            step();
        end
        chk("cred_regrant", 64'(n), 64'd1);
        chk("cred_regrant_tid", 64'(last), 64'h04);

        // back-pressure
        do_reset();
        start_run();
        ch_req_val  = 3'b001;
        ch_req_addr = {40'h0, 40'h0, 40'h4000};
        mem_req_rdy = 1'b0;
        #1;
        chk("bp_grant", 64'(ch_req_rdy), 64'b001);
        step();
        ch_req_addr = {40'h0, 40'h0, 40'h5000};
        n = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (!mem_req_val || mem_req_transid != 6'h00 ||
                mem_req_addr != 40'h4000 || ch_req_rdy != 3'b000) n++;
            step();
        end
        chk("bp_hold", 64'(n), 64'd0);
        mem_req_rdy = 1'b1;
        #1;
        chk("bp_rel_tid", 64'(mem_req_transid), 64'h00);
        chk("bp_rel_rdy", 64'(ch_req_rdy), 64'b001);
        step();
        ch_req_val = 3'b000;
        #1;
        chk("bp_next_tid", 64'(mem_req_transid), 64'h01);
        chk("bp_next_addr", 64'(mem_req_addr), 64'h5000);
        step();
        #1;
        chk("bp_no_dup", 64'(mem_req_val), 64'd0);

        // drain
        do_reset();
        start_run();
        ch_req_val  = 3'b010;
        ch_req_addr = {40'h0, 40'h2000, 40'h0};
        mem_req_rdy = 1'b1;
        #1;
        chk("dr_grant", 64'(ch_req_rdy), 64'b010);
        step();
        step();
        sched_flush = 1'b1;
        step();
        sched_flush = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ch_req_rdy != 3'b000 || !sched_busy || sched_done) n++;
            step();
        end
        chk("dr_no_grant", 64'(n), 64'd0);
        for (int j = 0; j < 3; j++) begin
            mem_resp_val     = 1'b1;
            mem_resp_transid = {2'b01, 4'(j)};
            #1;
            chk("dr_resp_val", 64'(ch_resp_val), 64'b010);
            chk("dr_resp_seq", 64'(ch_resp_seq), 64'(j));
            chk("dr_done_early", 64'(sched_done), 64'd0);
            step();
        end
        mem_resp_val = 1'b0;
        #1;
        chk("dr_done", 64'(sched_done), 64'd1);
        chk("dr_busy_hold", 64'(sched_busy), 64'd1);
        step();
        #1;
        chk("dr_done_pulse", 64'(sched_done), 64'd0);
        chk("dr_idle", 64'(sched_busy), 64'd0);

        // flush beats start in RUN
        do_reset();
        start_run();
        sched_start = 1'b1;
        sched_flush = 1'b1;
        step();
        sched_start = 1'b0;
        sched_flush = 1'b0;
        ch_req_val  = 3'b111;
        #1;
        chk("fw_no_grant", 64'(ch_req_rdy), 64'd0);
        chk("fw_done", 64'(sched_done), 64'd1);
        step();
        #1;
        chk("fw_idle", 64'(sched_busy), 64'd0);

        // seq wrap with immediate responses
        do_reset();
        start_run();
        mem_req_rdy = 1'b1;
        g = 0;
        h = 0;
        last = 6'h3f;
        for (int c = 0; c < 80 && h < 17; c++) begin
            ch_req_val       = (g < 17) ? 3'b001 : 3'b000;
            ch_req_addr      = 120'(g * 64);
            mem_resp_val     = mem_req_val;
            mem_resp_transid = mem_req_transid;
            #1;
            if (ch_req_rdy[0] && ch_req_val[0]) g++;
            if (mem_req_val && mem_req_rdy) begin
                chk("wrap_tid", 64'(mem_req_transid), 64'({2'b00, 4'(h % 16)}));
                last = mem_req_transid;
                h++;
            end
            step();
        end
        mem_resp_val = 1'b0;
        ch_req_val   = 3'b000;
        chk("wrap_count", 64'(h), 64'd17);
        chk("wrap_17th", 64'(last), 64'h00);
`ifdef SPM_SCHED_STATS_EN
        chk("stat_req", 64'(stat_req_cnt), 64'd17);
        chk("stat_stall0", 64'(stat_stall_cnt), 64'd0);
`endif
        ch_req_val  = 3'b001;
        mem_req_rdy = 1'b0;
        step();
        ch_req_val = 3'b000;
        for (int c = 0; c < 4; c++) step();
        #1;
        chk("stall_tid", 64'(mem_req_transid), 64'h01);
        chk("stall_val", 64'(mem_req_val), 64'd1);
`ifdef SPM_SCHED_STATS_EN
        chk("stat_stall", 64'(stat_stall_cnt), 64'd4);
        chk("stat_req_keep", 64'(stat_req_cnt), 64'd17);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
